// File: rtl/lexicode_search.sv
// Greedy lexicographic code search: accepts ascending candidates at distance >= min_dist from all prior codewords, then streams them.
// Optional LEXICODE_MIN_WEIGHT_EN adds the min_wt input, rejecting light candidates before any distance check.
module lexicode_search #(
  parameter int N     = 8,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] min_dist,
  input  logic [AW:0]   max_codes,
`ifdef LEXICODE_MIN_WEIGHT_EN
  input  logic [DW-1:0] min_wt,
`endif
  output logic          busy,
  output logic          done,
  output logic          overflow,
  output logic [AW:0]   code_count,
  output logic [N-1:0]  out_code,
  output logic [AW-1:0] out_index,
  output logic          out_valid,
  input  logic          out_ready
);

  typedef enum logic [3:0] {
    S_IDLE, S_CAND, S_RD, S_CMP, S_ACCEPT, S_NEXT, S_ORD, S_OVAL, S_FIN
  } state_t;

  localparam logic [N:0]  CAND_LAST = {1'b0, {N{1'b1}}};
  localparam logic [N:0]  CAND_ONE  = (N + 1)'(1);
  localparam logic [AW:0] CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW:0] DEPTH_C   = (AW + 1)'(DEPTH);

  state_t        state_q, state_d;
  logic [N:0]    cand_q, cand_d;
  logic [AW:0]   idx_q, idx_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [DW-1:0] mdist_q, mdist_d;
  logic [AW:0]   maxc_q, maxc_d;
  logic          ovf_q, ovf_d;
`ifdef LEXICODE_MIN_WEIGHT_EN
  logic [DW-1:0] mwt_q, mwt_d;
`endif

  logic [N-1:0]  mem [DEPTH];
  logic [N-1:0]  ram_q;
  logic          ram_we, ram_re;
  logic [AW-1:0] ram_addr;
  logic          search_end;

  function automatic logic [DW-1:0] popcnt(input logic [N-1:0] v);
    logic [DW-1:0] s;
    s = '0;
    for (int unsigned i = 0; i < N; i++) s = s + DW'(v[i]);
    return s;
  endfunction

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    mdist_d    = mdist_q;
    maxc_d     = maxc_q;
    ovf_d      = ovf_q;
`ifdef LEXICODE_MIN_WEIGHT_EN
    mwt_d      = mwt_q;
`endif
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = idx_q[AW-1:0];
    search_end = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mdist_d = (min_dist == '0) ? DW'(1) : min_dist;
          maxc_d  = max_codes;
`ifdef LEXICODE_MIN_WEIGHT_EN
          mwt_d   = min_wt;
`endif
          cand_d  = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_CAND;
        end
      end
      S_CAND: begin
        if (cnt_q == '0) begin
          state_d = S_ACCEPT;
        end else begin
          idx_d   = '0;
          state_d = S_RD;
        end
`ifdef LEXICODE_MIN_WEIGHT_EN
        // weight reject overrides either path chosen above
        if (popcnt(cand_q[N-1:0]) < mwt_q) state_d = S_NEXT;
`endif
      end
      S_RD: begin
        ram_re  = 1'b1;
        state_d = S_CMP;
      end
      S_CMP: begin
        if (popcnt(ram_q ^ cand_q[N-1:0]) < mdist_q) begin
          state_d = S_NEXT;
        end else if (idx_q == cnt_q - CNT_ONE) begin
          state_d = S_ACCEPT;
        end else begin
          idx_d   = idx_q + CNT_ONE;
          state_d = S_RD;
        end
      end
      S_ACCEPT: begin
        ram_we   = 1'b1;
        ram_addr = cnt_q[AW-1:0];
        cnt_d    = cnt_q + CNT_ONE;
        state_d  = S_NEXT;
      end
      S_NEXT: begin
        if (cand_q == CAND_LAST) begin
          search_end = 1'b1;
        end else if (maxc_q != '0 && cnt_q == maxc_q) begin
          search_end = 1'b1;
        end else if (cnt_q == DEPTH_C) begin
          ovf_d      = 1'b1;
          search_end = 1'b1;
        end else begin
          cand_d  = cand_q + CAND_ONE;
          state_d = S_CAND;
        end
        if (search_end) begin
          idx_d   = '0;
          state_d = S_ORD;
        end
      end
      S_ORD: begin
        if (idx_q == cnt_q) begin
          state_d = S_FIN;
        end else begin
          ram_re  = 1'b1;
          state_d = S_OVAL;
        end
      end
      S_OVAL: begin
        if (out_ready) begin
          idx_d   = idx_q + CNT_ONE;
          state_d = S_ORD;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cand_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      mdist_q <= '0;
      maxc_q  <= '0;
      ovf_q   <= 1'b0;
`ifdef LEXICODE_MIN_WEIGHT_EN
      mwt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mdist_q <= mdist_d;
      maxc_q  <= maxc_d;
      ovf_q   <= ovf_d;
`ifdef LEXICODE_MIN_WEIGHT_EN
      mwt_q   <= mwt_d;
`endif
    end
  end

  // ram_q only reloads on a read, so it holds the streamed word across stalls
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= cand_q[N-1:0];
    if (ram_re) ram_q <= mem[ram_addr];
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FIN);
  assign out_valid  = (state_q == S_OVAL);
  assign overflow   = ovf_q;
  assign code_count = cnt_q;
  assign out_code   = out_valid ? ram_q : '0;
  assign out_index  = out_valid ? idx_q[AW-1:0] : '0;

endmodule

// File: tb/tb_lexicode_search.sv
// Self-checking bench for lexicode_search: greedy-search reference model plus stream monitor over four parameterisations.
`timescale 1ns/1ps
module tb_lexicode_search;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] start_v;
  logic [2:0] md;
  logic [7:0] mc;
  logic       rdy;
`ifdef LEXICODE_MIN_WEIGHT_EN
  logic [2:0] mw;
`endif

  always #5 clk = ~clk;

  logic b0, d0, ov0, v0; logic [3:0] cc0; logic [2:0] c0; logic [2:0] i0;
  logic b1, d1, ov1, v1; logic [4:0] cc1; logic [3:0] c1; logic [3:0] i1;
  logic b2, d2, ov2, v2; logic [7:0] cc2; logic [6:0] c2; logic [6:0] i2;
  logic b3, d3, ov3, v3; logic [2:0] cc3; logic [3:0] c3; logic [1:0] i3;

  lexicode_search #(.N(3), .DEPTH(8)) u_n3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .min_dist(md[1:0]), .max_codes(mc[3:0]),
`ifdef LEXICODE_MIN_WEIGHT_EN
    .min_wt(mw[1:0]),
`endif
    .busy(b0), .done(d0), .overflow(ov0), .code_count(cc0), .out_code(c0),
    .out_index(i0), .out_valid(v0), .out_ready(rdy));

  lexicode_search #(.N(4), .DEPTH(16)) u_n4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .min_dist(md), .max_codes(mc[4:0]),
`ifdef LEXICODE_MIN_WEIGHT_EN
    .min_wt(mw),
`endif
    .busy(b1), .done(d1), .overflow(ov1), .code_count(cc1), .out_code(c1),
    .out_index(i1), .out_valid(v1), .out_ready(rdy));

  lexicode_search #(.N(7), .DEPTH(128)) u_n7 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .min_dist(md), .max_codes(mc),
`ifdef LEXICODE_MIN_WEIGHT_EN
    .min_wt(mw),
`endif
    .busy(b2), .done(d2), .overflow(ov2), .code_count(cc2), .out_code(c2),
    .out_index(i2), .out_valid(v2), .out_ready(rdy));

  lexicode_search #(.N(4), .DEPTH(4)) u_n4d4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .min_dist(md), .max_codes(mc[2:0]),
`ifdef LEXICODE_MIN_WEIGHT_EN
    .min_wt(mw),
`endif
    .busy(b3), .done(d3), .overflow(ov3), .code_count(cc3), .out_code(c3),
    .out_index(i3), .out_valid(v3), .out_ready(rdy));

  int   sel;
  logic ob, od, oov, ovl;
  int   occ, oc, oi;

  always_comb begin
    ob = b0; od = d0; oov = ov0; ovl = v0; occ = int'(cc0); oc = int'(c0); oi = int'(i0);
    case (sel)
      1: begin ob = b1; od = d1; oov = ov1; ovl = v1; occ = int'(cc1); oc = int'(c1); oi = int'(i1); end
      2: begin ob = b2; od = d2; oov = ov2; ovl = v2; occ = int'(cc2); oc = int'(c2); oi = int'(i2); end
      3: begin ob = b3; od = d3; oov = ov3; ovl = v3; occ = int'(cc3); oc = int'(c3); oi = int'(i3); end
      default: ;
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: plain greedy lexicode over all 2**n candidates with the stop rules.
  int exp_q[$];
  int exp_ovf;

  task automatic build_model(input int n, input int d, input int maxc, input int depth, input int wt);
    int dd;
    bit ok;
    exp_q.delete();
    exp_ovf = 0;
    dd = (d == 0) ? 1 : d;
    for (int c = 0; c < (1 << n); c++) begin
      ok = ($countones(c) >= wt);
      foreach (exp_q[k]) if ($countones(exp_q[k] ^ c) < dd) ok = 1'b0;
      if (ok) exp_q.push_back(c);
      if (c == (1 << n) - 1) break;
      if (maxc != 0 && exp_q.size() == maxc) break;
      if (exp_q.size() == depth) begin
        exp_ovf = 1;
        break;
      end
    end
  endtask

  int hs_cnt, done_cnt;
  int got_q[$];
  bit mon_en;

  initial begin
    bit pv, pr;
    int pc, pi;
    pv = 1'b0; pr = 1'b0; pc = 0; pi = 0;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        if (pv && !pr) begin
          chk("stall_valid_held", int'(ovl), 1);
          chk("stall_code_held", oc, pc);
          chk("stall_index_held", oi, pi);
        end
        if (ovl && rdy) begin
          if (hs_cnt < exp_q.size()) chk("out_code", oc, exp_q[hs_cnt]);
          else chk("extra_handshake", hs_cnt, exp_q.size());
          chk("out_index", oi, hs_cnt);
          got_q.push_back(oc);
          hs_cnt++;
        end
        if (od) begin
          done_cnt++;
          chk("done_after_last_handshake", hs_cnt, exp_q.size());
        end
        pv = ovl; pr = rdy; pc = oc; pi = oi;
      end else begin
        pv = 1'b0; pr = 1'b0;
      end
    end
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, int'(ob), 0);
    chk({tag, "_done"}, int'(od), 0);
    chk({tag, "_overflow"}, int'(oov), 0);
    chk({tag, "_out_valid"}, int'(ovl), 0);
    chk({tag, "_code_count"}, occ, 0);
    chk({tag, "_out_code"}, oc, 0);
    chk({tag, "_out_index"}, oi, 0);
  endtask

  task automatic pulse_start(input int s);
    @(posedge clk); #1;
    start_v[s] = 1'b1;
    @(posedge clk); #1;
    start_v = '0;
  endtask

  task automatic run(input int s, input int n, input int d, input int maxc, input int depth,
                     input int wt, input bit rnd, input string tag);
    int cyc;
    build_model(n, d, maxc, depth, wt);
    sel = s;
    md  = 3'(d);
    mc  = 8'(maxc);
`ifdef LEXICODE_MIN_WEIGHT_EN
    mw  = 3'(wt);
`endif
    hs_cnt = 0; done_cnt = 0; got_q.delete();
    rdy = 1'b1;
    mon_en = 1'b1;
    pulse_start(s);
    chk({tag, "_busy_rise"}, int'(ob), 1);
    cyc = 0;
    while (ob && cyc < 20000) begin
      @(posedge clk); #1;
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc++;
    end
    rdy = 1'b1;
    chk({tag, "_finished"}, int'(ob), 0);
    if (ob) begin
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
    end
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_handshakes"}, hs_cnt, exp_q.size());
    chk({tag, "_code_count"}, occ, exp_q.size());
    chk({tag, "_overflow"}, int'(oov), exp_ovf);
  endtask

  task automatic pair_check(input int d);
    int bad;
    bad = 0;
    foreach (got_q[i])
      for (int j = i + 1; j < got_q.size(); j++)
        if ($countones(got_q[i] ^ got_q[j]) < d) bad++;
    chk("pairwise_distance_violations", bad, 0);
  endtask

  initial begin
    int n4d2_lit[8];
    n4d2_lit = '{0, 3, 5, 6, 9, 10, 12, 15};
    rst_n = 1'b0; start_v = '0; md = '0; mc = '0; rdy = 1'b1; sel = 0; mon_en = 1'b0;
`ifdef LEXICODE_MIN_WEIGHT_EN
    mw = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      chk_idle($sformatf("reset_inst%0d", s));
    end
    rst_n = 1'b1;

    // Hand-computed pins on the reference model itself
    build_model(3, 3, 0, 8, 0);
    chk("model_n3_size", exp_q.size(), 2);
    chk("model_n3_second", exp_q[1], 7);
    build_model(4, 2, 0, 16, 0);
    chk("model_n4_size", exp_q.size(), 8);
    foreach (n4d2_lit[k]) chk($sformatf("model_n4_code%0d", k), exp_q[k], n4d2_lit[k]);
    build_model(7, 3, 0, 128, 0);
    chk("model_n7_size", exp_q.size(), 16);
    chk("model_n7_c1", exp_q[1], 'h07);
    chk("model_n7_c2", exp_q[2], 'h19);
    chk("model_n7_c3", exp_q[3], 'h1E);
    chk("model_n7_last", exp_q[15], 'h7F);
    build_model(4, 1, 0, 4, 0);
    chk("model_depth4_ovf", exp_ovf, 1);
    chk("model_depth4_last", exp_q[3], 3);

    run(0, 3, 3, 0, 8, 0, 1'b0, "n3d3");
    run(1, 4, 2, 0, 16, 0, 1'b0, "n4d2");
    run(2, 7, 3, 0, 128, 0, 1'b0, "n7d3");
    pair_check(3);
    run(1, 4, 2, 3, 16, 0, 1'b1, "n4max3_stall");
    run(3, 4, 1, 0, 4, 0, 1'b0, "n4depth4");
    run(1, 4, 0, 0, 16, 0, 1'b1, "n4d0");

    // Abort during the compare of candidate 2 (N=3, d=3)
    build_model(3, 3, 0, 8, 0);
    sel = 0; md = 3'd3; mc = '0;
    hs_cnt = 0; done_cnt = 0; got_q.delete();
    pulse_start(0);
    repeat (9) @(posedge clk);
    #1;
    chk("pre_reset_busy", int'(ob), 1);
    chk("pre_reset_code_count", occ, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_idle("mid_search_reset");
    chk("mid_search_reset_no_done", done_cnt, 0);
    rst_n = 1'b1;
    run(0, 3, 3, 0, 8, 0, 1'b0, "n3d3_after_reset");

`ifdef LEXICODE_MIN_WEIGHT_EN
    build_model(4, 2, 0, 16, 2);
    chk("model_wt2_size", exp_q.size(), 7);
    chk("model_wt2_first", exp_q[0], 3);
    run(1, 4, 2, 0, 16, 2, 1'b0, "n4wt2");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
